// File: rtl/cobertura_motor_pkg.sv
// cobertura_motor shared types: FSM states, travel direction, output bundle.
// Also holds the registered-output decode used by the top.
package cobertura_motor_pkg;

    typedef enum logic [2:0] {
        PARADO   = 3'd0,
        MORTO    = 3'd1,
        ABRINDO  = 3'd2,
        FECHANDO = 3'd3,
        FALHA    = 3'd4
    } estado_t;

    typedef enum logic {
        ABRE  = 1'b0,
        FECHA = 1'b1
    } dir_t;

    typedef struct packed {
        logic motor_abre;
        logic motor_fecha;
        logic em_movimento;
        logic falha;
    } saidas_t;

    function automatic saidas_t decodifica(estado_t e);
        saidas_t s;
        s.motor_abre   = (e == ABRINDO);
        s.motor_fecha  = (e == FECHANDO);
        s.em_movimento = (e == ABRINDO) || (e == FECHANDO);
        s.falha        = (e == FALHA);
        return s;
    endfunction

endpackage

// File: rtl/cobertura_motor_if.sv
// Command, limit-switch and motor-drive bundle between cobertura and the motor.
// master drives commands/switches, slave is the motor driver.
interface cobertura_motor_if;

    logic abrir;
    logic fechar;
    logic fim_aberta;
    logic fim_fechada;
    logic limpa;
    logic motor_abre;
    logic motor_fecha;
    logic em_movimento;
    logic falha;

    modport master (
        output abrir,
        output fechar,
        output fim_aberta,
        output fim_fechada,
        output limpa,
        input  motor_abre,
        input  motor_fecha,
        input  em_movimento,
        input  falha
    );

    modport slave (
        input  abrir,
        input  fechar,
        input  fim_aberta,
        input  fim_fechada,
        input  limpa,
        output motor_abre,
        output motor_fecha,
        output em_movimento,
        output falha
    );

endinterface

// File: rtl/cobertura_motor_sinc2.sv
// Two-flop synchronizer for an asynchronous limit switch.
// Clears to 0 on reset.
module cobertura_motor_sinc2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/cobertura_motor.sv
// Reversible roof-motor driver: dead time, limit stop, travel timeout, fault latch.
// Close requests win over open requests so rain always shuts the roof.
module cobertura_motor
    import cobertura_motor_pkg::*;
#(
    parameter int T_MORTO  = 4,
    parameter int T_LIMITE = 1000,
    parameter int W_CNT    = 16
) (
    input logic              clk,
    input logic              rst_n,
    cobertura_motor_if.slave bus
);

    localparam logic [W_CNT-1:0] ULT_MORTO  = W_CNT'(T_MORTO - 1);
    localparam logic [W_CNT-1:0] ULT_LIMITE = W_CNT'(T_LIMITE - 1);
    localparam logic [W_CNT-1:0] CNT_MAX    = '1;
    localparam logic [W_CNT-1:0] UM         = W_CNT'(1);

    logic fa_s;
    logic ff_s;

    estado_t          est;
    estado_t          est_nxt;
    dir_t             dir;
    dir_t             dir_nxt;
    logic [W_CNT-1:0] cnt;
    logic [W_CNT-1:0] cnt_nxt;
    logic [W_CNT-1:0] cnt_inc;
    saidas_t          sai_q;
    saidas_t          sai_nxt;

    logic pede_fecha;
    logic pede_abre;
    logic incoerente;

    cobertura_motor_sinc2 u_sinc_fa (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.fim_aberta),
        .q     (fa_s)
    );

    cobertura_motor_sinc2 u_sinc_ff (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.fim_fechada),
        .q     (ff_s)
    );

    assign pede_fecha = bus.fechar & ~ff_s;
    assign pede_abre  = ~pede_fecha & bus.abrir & ~fa_s;
    assign incoerente = fa_s & ff_s;
    assign cnt_inc    = (cnt == CNT_MAX) ? cnt : cnt + UM;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            est   <= PARADO;
            dir   <= ABRE;
            cnt   <= '0;
            sai_q <= '0;
        end else begin
            est   <= est_nxt;
            dir   <= dir_nxt;
            cnt   <= cnt_nxt;
            sai_q <= sai_nxt;
        end
    end

    always_comb begin
        est_nxt = est;
        dir_nxt = dir;
        cnt_nxt = cnt_inc;
        if (incoerente) begin
            est_nxt = FALHA;
            cnt_nxt = '0;
        end else begin
            unique case (est)
                PARADO: begin
                    cnt_nxt = '0;
                    if (pede_fecha) begin
                        est_nxt = MORTO;
                        dir_nxt = FECHA;
                    end else if (pede_abre) begin
                        est_nxt = MORTO;
                        dir_nxt = ABRE;
                    end
                end
                MORTO: begin
                    if (cnt == ULT_MORTO) begin
                        cnt_nxt = '0;
                        if (pede_fecha) begin
                            est_nxt = FECHANDO;
                            dir_nxt = FECHA;
                        end else if (pede_abre) begin
                            est_nxt = ABRINDO;
                            dir_nxt = ABRE;
                        end else begin
                            est_nxt = PARADO;
                        end
                    end
                end
                ABRINDO: begin
                    if (fa_s) begin
                        est_nxt = PARADO;
                        cnt_nxt = '0;
                    end else if (pede_fecha) begin
                        est_nxt = MORTO;
                        dir_nxt = FECHA;
                        cnt_nxt = '0;
                    end else if (!bus.abrir) begin
                        est_nxt = PARADO;
                        cnt_nxt = '0;
                    end else if (cnt == ULT_LIMITE) begin
                        est_nxt = FALHA;
                        cnt_nxt = '0;
                    end
                end
                FECHANDO: begin
                    // open can only reverse once fechar has dropped
                    if (ff_s) begin
                        est_nxt = PARADO;
                        cnt_nxt = '0;
                    end else if (!bus.fechar) begin
                        cnt_nxt = '0;
                        if (pede_abre) begin
                            est_nxt = MORTO;
                            dir_nxt = ABRE;
                        end else begin
                            est_nxt = PARADO;
                        end
                    end else if (cnt == ULT_LIMITE) begin
                        est_nxt = FALHA;
                        cnt_nxt = '0;
                    end
                end
                FALHA: begin
                    cnt_nxt = '0;
                    if (bus.limpa) begin
                        est_nxt = PARADO;
                    end
                end
                default: begin
                    est_nxt = PARADO;
                    cnt_nxt = '0;
                end
            endcase
        end
    end

    always_comb begin
        sai_nxt = decodifica(est_nxt);
    end

    assign bus.motor_abre   = sai_q.motor_abre;
    assign bus.motor_fecha  = sai_q.motor_fecha;
    assign bus.em_movimento = sai_q.em_movimento;
    assign bus.falha        = sai_q.falha;

endmodule

// File: tb/tb_cobertura_motor.sv
// Bench for cobertura_motor: vector table plus hand sequences,
// expected outputs queued at drive time and popped after each edge.
module tb_cobertura_motor;

    localparam int TM = 4;
    localparam int TL = 20;

    typedef struct {
        string      nome;
        logic       ab;
        logic       fe;
        logic       fa;
        logic       ff;
        logic       lp;
        logic [3:0] e;
    } vec_t;

    typedef struct {
        string      nome;
        logic [3:0] e;
    } esp_t;

    logic clk;
    logic rst_n;

    cobertura_motor_if bus_if ();

    cobertura_motor #(
        .T_MORTO  (TM),
        .T_LIMITE (TL),
        .W_CNT    (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if.slave)
    );

    int   total;
    int   bad;
    vec_t tab[$];
    esp_t esp_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end

    function automatic logic [3:0] saidas();
        return {bus_if.motor_abre, bus_if.motor_fecha,
                bus_if.em_movimento, bus_if.falha};
    endfunction

    task automatic add(string n, logic ab, logic fe, logic fa,
                       logic ff, logic lp, logic [3:0] e, int rep);
        vec_t v;
        v.nome = n;
        v.ab = ab;
        v.fe = fe;
        v.fa = fa;
        v.ff = ff;
        v.lp = lp;
        v.e  = e;
        for (int i = 0; i < rep; i++) tab.push_back(v);
    endtask

    task automatic confere();
        esp_t x;
        logic [3:0] got;
        x   = esp_q.pop_front();
        got = saidas();
        total++;
        if (got !== x.e) begin
            bad++;
            $display("FAIL %s: got ma/mf/em/fl=%b want %b", x.nome, got, x.e);
        end
        total++;
        if (got[3] & got[2]) begin
            bad++;
            $display("FAIL %s_excl: got both motors=%b want 0", x.nome, got[3:2]);
        end
    endtask

    task automatic apply(vec_t v);
        esp_t x;
        bus_if.abrir       = v.ab;
        bus_if.fechar      = v.fe;
        bus_if.fim_aberta  = v.fa;
        bus_if.fim_fechada = v.ff;
        bus_if.limpa       = v.lp;
        x.nome = v.nome;
        x.e    = v.e;
        esp_q.push_back(x);
        @(posedge clk);
        #1;
        confere();
    endtask

    task automatic step(string n, logic ab, logic fe, logic fa,
                        logic ff, logic lp, logic [3:0] e, int rep);
        vec_t v;
        v.nome = n;
        v.ab = ab;
        v.fe = fe;
        v.fa = fa;
        v.ff = ff;
        v.lp = lp;
        v.e  = e;
        for (int i = 0; i < rep; i++) apply(v);
    endtask

    initial begin
        esp_t x;
        total = 0;
        bad   = 0;
        // outputs as {motor_abre, motor_fecha, em_movimento, falha}
        add("arranque",   1, 0, 0, 0, 0, 4'b0000, TM);
        add("abre",       1, 0, 0, 0, 0, 4'b1010, 2);
        add("fim_ab",     1, 0, 1, 0, 0, 4'b1010, 2);
        add("para_fim",   1, 0, 1, 0, 0, 4'b0000, 3);
        add("solta",      0, 0, 0, 0, 0, 4'b0000, 3);
        add("arr2",       1, 0, 0, 0, 0, 4'b0000, TM);
        add("abre2",      1, 0, 0, 0, 0, 4'b1010, 2);
        add("inverte",    1, 1, 0, 0, 0, 4'b0000, TM);
        add("fecha_inv",  1, 1, 0, 0, 0, 4'b0110, 2);
        add("larga",      0, 0, 0, 0, 0, 4'b0000, 1);
        add("ambos",      1, 1, 0, 0, 0, 4'b0000, TM);
        add("prio_fecha", 1, 1, 0, 0, 0, 4'b0110, 1);
        add("fim_fe",     0, 1, 0, 1, 0, 4'b0110, 2);
        add("para_fe",    0, 1, 0, 1, 0, 4'b0000, 2);
        add("solta2",     0, 0, 0, 0, 0, 4'b0000, 3);
        add("arr3",       0, 1, 0, 0, 0, 4'b0000, TM);
        add("fecha3",     0, 1, 0, 0, 0, 4'b0110, 1);
        add("rev_ab",     1, 0, 0, 0, 0, 4'b0000, TM);
        add("abre3",      1, 0, 0, 0, 0, 4'b1010, 1);
        add("larga2",     0, 0, 0, 0, 0, 4'b0000, 1);

        rst_n              = 1'b0;
        bus_if.abrir       = 1'b0;
        bus_if.fechar      = 1'b0;
        bus_if.fim_aberta  = 1'b0;
        bus_if.fim_fechada = 1'b0;
        bus_if.limpa       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        x.nome = "reset";
        x.e    = 4'b0000;
        esp_q.push_back(x);
        confere();
        rst_n = 1'b1;

        for (int i = 0; i < tab.size(); i++) apply(tab[i]);

        step("t_morto",    1, 0, 0, 0, 0, 4'b0000, TM);
        step("t_abre",     1, 0, 0, 0, 0, 4'b1010, TL);
        step("timeout",    1, 0, 0, 0, 0, 4'b0001, 1);
        step("falha_fica", 0, 0, 0, 0, 0, 4'b0001, 1);
        step("limpa",      0, 0, 0, 0, 1, 4'b0000, 1);
        step("parado",     0, 0, 0, 0, 0, 4'b0000, 1);

        step("i_morto",    0, 1, 0, 0, 0, 4'b0000, TM);
        step("i_fecha",    0, 1, 0, 0, 0, 4'b0110, 1);
        step("i_sinc",     0, 1, 1, 1, 0, 4'b0110, 2);
        step("incons",     0, 1, 1, 1, 0, 4'b0001, 1);
        step("bloq",       0, 0, 1, 1, 1, 4'b0001, 1);
        step("bloq_sinc",  0, 0, 0, 0, 1, 4'b0001, 2);
        step("sai_falha",  0, 0, 0, 0, 1, 4'b0000, 1);
        step("pos_falha",  0, 0, 0, 0, 0, 4'b0000, 1);

        step("r_morto",    1, 0, 0, 0, 0, 4'b0000, TM);
        step("r_abre",     1, 0, 0, 0, 0, 4'b1010, 1);
        #3;
        rst_n = 1'b0;
        #1;
        x.nome = "rst_async";
        x.e    = 4'b0000;
        esp_q.push_back(x);
        confere();
        @(posedge clk);
        #1;
        x.nome = "rst_hold";
        esp_q.push_back(x);
        confere();
        rst_n = 1'b1;
        step("pr_morto",   1, 0, 0, 0, 0, 4'b0000, TM);
        step("pr_abre",    1, 0, 0, 0, 0, 4'b1010, 1);
        step("pr_larga",   0, 0, 0, 0, 0, 4'b0000, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
